imm_extend_stage: RTL and testbench

Parametrised, registered immediate-extension pipeline stage for the 16-bit pipelined RISC datapath. It accepts a raw instruction immediate field of programmable length and widens it to the datapath width. Four modes are supported: sign-extend, zero-extend, sign-extend-and-shift (branch offsets) and upper-immediate placement. The block sits between decode and the operand-select mux and uses a valid/ready handshake with a two-entry skid buffer, so decode stalls and pipeline flushes never lose or duplicate an immediate.

---
 rtl/imm_extend_stage_if.sv | 36 +++
 rtl/imm_extend_stage.sv | 126 ++++++++++++
 tb/tb_imm_extend_stage.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/imm_extend_stage_if.sv
// Handshake bundle for imm_extend_stage.
//   in_*  : producer side (decode) -> stage, valid/ready
//   out_* : stage -> consumer (operand-select mux), valid/ready
// Handshake rule on both sides: a transfer happens on a rising clock edge
// where valid && ready are both high. A source that raises valid holds its
// payload stable until that transfer happens.
// modport slave  : the extension stage itself.
// modport master : the environment that drives inputs and consumes outputs.
interface imm_extend_stage_if #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 16,
    parameter int TAG_W = 4,
    parameter int LEN_W = $clog2(IN_W) + 1
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [LEN_W-1:0] in_len;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_ovf;

    modport master (
        output in_valid, in_imm, in_len, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_ovf
    );

    modport slave (
        input  in_valid, in_imm, in_len, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_ovf
    );
endinterface

// File: rtl/imm_extend_stage.sv
// Registered immediate-extension stage with a two-entry skid buffer.
// Widens a right-aligned raw immediate of programmable length to OUT_W bits
// using one of four modes (SEXT, ZEXT, SEXT_SHL, UPPER) and passes a sideband
// tag through unchanged.
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous active-high reset
//   flush  : synchronous flush, drops every held entry
//   bus    : imm_extend_stage_if.slave (in_* request side, out_* result side)
// Storage: main register M drives out_*; skid register S catches the entry
// accepted while M is stalled, so in_ready can come straight from a flop.
module imm_extend_stage #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 16,
    parameter int SHIFT = 1,
    parameter int TAG_W = 4,
    parameter int LEN_W = $clog2(IN_W) + 1
) (
    input  logic clock,
    input  logic reset,
    input  logic flush,
    imm_extend_stage_if.slave bus
);
    localparam int SH_W = $clog2(OUT_W) + 1;

    typedef enum logic [1:0] {
        MODE_SEXT     = 2'b00,
        MODE_ZEXT     = 2'b01,
        MODE_SEXT_SHL = 2'b10,
        MODE_UPPER    = 2'b11
    } mode_e;

    // Combinational extension of the offered entry.
    logic [LEN_W-1:0] eff_len;
    logic [SH_W-1:0]  up_sh;
    logic [OUT_W-1:0] imm_wide, mask, field, sext, ext_imm;
    logic [SHIFT:0]   top_bits;
    logic             sign, ext_ovf;

    always_comb begin
        // in_len of 0 or beyond IN_W selects the full input width.
        if (bus.in_len == '0 || bus.in_len > LEN_W'(IN_W))
            eff_len = LEN_W'(IN_W);
        else
            eff_len = bus.in_len;

        imm_wide = OUT_W'(bus.in_imm);
        mask     = ~({OUT_W{1'b1}} << eff_len);
        field    = imm_wide & mask;
        // mask & ~(mask >> 1) isolates bit L-1, the sign bit of the field.
        sign     = |(field & (mask & ~(mask >> 1)));
        sext     = field | (sign ? ~mask : '0);
        up_sh    = SH_W'(OUT_W) - SH_W'(eff_len);
        // Bits lost or overwritten by the shift must all equal the new sign.
        top_bits = sext[OUT_W-1 -: SHIFT+1];

        ext_imm = '0;
        ext_ovf = 1'b0;
        case (mode_e'(bus.in_mode))
            MODE_SEXT:     ext_imm = sext;
            MODE_ZEXT:     ext_imm = field;
            MODE_SEXT_SHL: begin
                ext_imm = sext << SHIFT;
                ext_ovf = !((&top_bits) || !(|top_bits));
            end
            MODE_UPPER:    ext_imm = field << up_sh;
            default:       ext_imm = '0;
        endcase
    end

    // Storage.
    logic             m_valid, s_valid;
    logic [OUT_W-1:0] m_imm, s_imm;
    logic [TAG_W-1:0] m_tag, s_tag;
    logic             m_ovf, s_ovf;
    logic             accept, drain;

    assign bus.in_ready  = !s_valid;
    assign bus.out_valid = m_valid;
    assign bus.out_imm   = m_imm;
    assign bus.out_tag   = m_tag;
    assign bus.out_ovf   = m_ovf;

    assign accept = bus.in_valid && bus.in_ready && !flush && !reset;
    assign drain  = m_valid && bus.out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_imm   <= '0;
            m_tag   <= '0;
            m_ovf   <= 1'b0;
            s_imm   <= '0;
            s_tag   <= '0;
            s_ovf   <= 1'b0;
        end else if (flush) begin
            // Data registers keep stale contents; only occupancy is dropped.
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else begin
            if (!m_valid || drain) begin
                if (s_valid) begin
                    m_imm   <= s_imm;
                    m_tag   <= s_tag;
                    m_ovf   <= s_ovf;
                    m_valid <= 1'b1;
                    s_valid <= 1'b0;
                end else if (accept) begin
                    m_imm   <= ext_imm;
                    m_tag   <= bus.in_tag;
                    m_ovf   <= ext_ovf;
                    m_valid <= 1'b1;
                end else begin
                    m_valid <= 1'b0;
                end
            end else if (accept) begin
                // M is stalled: park the new entry in the skid register.
                s_imm   <= ext_imm;
                s_tag   <= bus.in_tag;
                s_ovf   <= ext_ovf;
                s_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_imm_extend_stage.sv
module tb_imm_extend_stage;
  logic clock = 1'b0;
  logic reset, flush;
  logic reset_b, flush_b;
  int n_vec  = 0;
  int n_miss = 0;

  always #5 clock = ~clock;

  imm_extend_stage_if #(.IN_W(12), .OUT_W(16), .TAG_W(4)) bus_a ();
  imm_extend_stage_if #(.IN_W(16), .OUT_W(16), .TAG_W(4)) bus_b ();

  imm_extend_stage #(.IN_W(12), .OUT_W(16), .SHIFT(1), .TAG_W(4)) dut_a (
    .clock(clock), .reset(reset), .flush(flush), .bus(bus_a)
  );

  imm_extend_stage #(.IN_W(16), .OUT_W(16), .SHIFT(1), .TAG_W(4)) dut_b (
    .clock(clock), .reset(reset_b), .flush(flush_b), .bus(bus_b)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer one entry to dut_a with out_ready high, check it one cycle later.
  task automatic vec_a(input string name, input logic [11:0] imm, input logic [4:0] len,
                       input logic [1:0] mode, input logic [3:0] tag,
                       input logic [15:0] exp_imm, input logic exp_ovf);
    bus_a.in_valid = 1'b1;
    bus_a.in_imm   = imm;
    bus_a.in_len   = len;
    bus_a.in_mode  = mode;
    bus_a.in_tag   = tag;
    tick();
    bus_a.in_valid = 1'b0;
    check({name, ".valid"}, 32'(bus_a.out_valid), 32'd1);
    check({name, ".imm"},   32'(bus_a.out_imm),   32'(exp_imm));
    check({name, ".ovf"},   32'(bus_a.out_ovf),   32'(exp_ovf));
    check({name, ".tag"},   32'(bus_a.out_tag),   32'(tag));
    tick();
  endtask

  task automatic vec_b(input string name, input logic [15:0] imm,
                       input logic [15:0] exp_imm, input logic exp_ovf);
    bus_b.in_valid = 1'b1;
    bus_b.in_imm   = imm;
    bus_b.in_len   = 5'd0;
    bus_b.in_mode  = 2'b10;
    bus_b.in_tag   = 4'h5;
    tick();
    bus_b.in_valid = 1'b0;
    check({name, ".valid"}, 32'(bus_b.out_valid), 32'd1);
    check({name, ".imm"},   32'(bus_b.out_imm),   32'(exp_imm));
    check({name, ".ovf"},   32'(bus_b.out_ovf),   32'(exp_ovf));
    tick();
  endtask

  // Park two entries (M then S) in dut_a while the consumer stalls.
  task automatic fill_two();
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_mode   = 2'b00;
    bus_a.in_len    = 5'd12;
    bus_a.in_imm    = 12'h7A1;
    bus_a.in_tag    = 4'h9;
    tick();
    bus_a.in_imm    = 12'h0B2;
    bus_a.in_tag    = 4'hA;
    tick();
    check("fill.in_ready", 32'(bus_a.in_ready), 32'd0);
    check("fill.out_valid", 32'(bus_a.out_valid), 32'd1);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; reset_b = 1'b1; flush_b = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_imm = '0; bus_a.in_len = '0;
    bus_a.in_mode = '0; bus_a.in_tag = '0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_imm = '0; bus_b.in_len = '0;
    bus_b.in_mode = '0; bus_b.in_tag = '0; bus_b.out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0; reset_b = 1'b0;
    tick();

    check("rst.out_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst.in_ready",  32'(bus_a.in_ready),  32'd1);
    check("rst.out_imm",   32'(bus_a.out_imm),   32'd0);

    // Extension modes on the default instance.
    vec_a("sext_l4_neg",  12'h00A, 5'd4,  2'b00, 4'h1, 16'hFFFA, 1'b0);
    vec_a("sext_l4_pos",  12'h006, 5'd4,  2'b00, 4'h2, 16'h0006, 1'b0);
    vec_a("zext_l8",      12'hF85, 5'd8,  2'b01, 4'h3, 16'h0085, 1'b0);
    vec_a("sext_l8",      12'hF85, 5'd8,  2'b00, 4'h4, 16'hFF85, 1'b0);
    vec_a("sext_len0",    12'h800, 5'd0,  2'b00, 4'h5, 16'hF800, 1'b0);
    vec_a("sext_len13",   12'h800, 5'd13, 2'b00, 4'h6, 16'hF800, 1'b0);
    vec_a("shl_l12_neg",  12'h800, 5'd12, 2'b10, 4'h7, 16'hF000, 1'b0);
    vec_a("shl_l12_pos",  12'h400, 5'd12, 2'b10, 4'h8, 16'h0800, 1'b0);
    vec_a("upper_l8",     12'h012, 5'd8,  2'b11, 4'h9, 16'h1200, 1'b0);
    vec_a("upper_l4",     12'h00F, 5'd4,  2'b11, 4'hA, 16'hF000, 1'b0);
    vec_a("upper_l12",    12'hABC, 5'd12, 2'b11, 4'hB, 16'hABC0, 1'b0);

    // Full-width instance where the shift can overflow.
    vec_b("b_shl_ovf",    16'h4000, 16'h8000, 1'b1);
    vec_b("b_shl_noovf",  16'hC000, 16'h8000, 1'b0);

    // Backpressure: tags 1,2,3 offered back-to-back with the consumer stalled.
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_mode   = 2'b00;
    bus_a.in_len    = 5'd12;
    bus_a.in_imm    = 12'h111; bus_a.in_tag = 4'h1;
    tick();
    check("bp.t1_in_ready", 32'(bus_a.in_ready), 32'd1);
    bus_a.in_imm    = 12'h222; bus_a.in_tag = 4'h2;
    tick();
    check("bp.in_ready_low", 32'(bus_a.in_ready), 32'd0);
    check("bp.hold_tag",     32'(bus_a.out_tag),  32'd1);
    bus_a.in_imm    = 12'h333; bus_a.in_tag = 4'h3;
    tick();
    check("bp.stable_tag", 32'(bus_a.out_tag), 32'd1);
    check("bp.stable_imm", 32'(bus_a.out_imm), 32'h0111);
    check("bp.still_full", 32'(bus_a.in_ready), 32'd0);
    bus_a.out_ready = 1'b1;
    tick();
    check("bp.out2_tag", 32'(bus_a.out_tag), 32'd2);
    check("bp.out2_imm", 32'(bus_a.out_imm), 32'h0222);
    check("bp.ready_back", 32'(bus_a.in_ready), 32'd1);
    tick();
    bus_a.in_valid = 1'b0;
    check("bp.out3_tag", 32'(bus_a.out_tag), 32'd3);
    check("bp.out3_imm", 32'(bus_a.out_imm), 32'h0333);
    tick();
    check("bp.drained", 32'(bus_a.out_valid), 32'd0);

    // Flush with M and S full and a third entry offered in the flush cycle.
    fill_two();
    bus_a.in_imm = 12'h0C3; bus_a.in_tag = 4'hB;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus_a.in_valid = 1'b0;
    check("flush.out_valid", 32'(bus_a.out_valid), 32'd0);
    check("flush.in_ready",  32'(bus_a.in_ready),  32'd1);
    bus_a.out_ready = 1'b1;
    tick(); tick();
    check("flush.no_ghost", 32'(bus_a.out_valid), 32'd0);

    // Reset with M and S full.
    fill_two();
    bus_a.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("rst2.out_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst2.in_ready",  32'(bus_a.in_ready),  32'd1);
    check("rst2.out_imm",   32'(bus_a.out_imm),   32'd0);
    check("rst2.out_tag",   32'(bus_a.out_tag),   32'd0);
    check("rst2.out_ovf",   32'(bus_a.out_ovf),   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
